// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch front-end: opcodes, field positions, fetch FSM states.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package cpu_isa_pkg;

  // Primary opcodes seen by the control decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Instruction field positions
  localparam int OPC_MSB    = 31;
  localparam int OPC_LSB    = 26;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  // Fetch FSM encoding; the unused code 2'd3 is steered back to IDLE by the FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

  // Opcode field of a 32-bit instruction word
  function automatic logic [5:0] get_opcode(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump target, taken-branch target, or the sequential address.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by the fetch unit on its commit edge.
module next_pc_calc
  import cpu_isa_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;

  // Region-relative jump keeps the top nibble of pc+4; branch offset is a sign-extended word count
  assign jump_target   = {pc_plus4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
  assign branch_offset = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;

  // Jump outranks a simultaneously flagged taken branch
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: holds the PC, fetches one word per req/ack transaction, commits the next PC.
// Latency: instr_valid rises on the edge that samples imem_ack; minimum 2 cycles per instruction.
// Backpressure: imem_req held until imem_ack (wait states stretch FETCH); instr held until exec_done.
module instr_fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        opcode,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              exec_done,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump
);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic              load_instr;
  logic              commit_pc;
  logic [ADDR_W-1:0] next_pc;

  // State register; reset lands in IDLE so imem_req drops immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobes; inputs outside their owning state are ignored by construction
  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    load_instr = 1'b0;
    commit_pc  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          load_instr = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        if (exec_done) begin
          commit_pc = 1'b1;
          state_d   = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the fetched word and track whether it is still awaiting execution
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (load_instr) begin
      instr_q <= imem_rdata;
      valid_q <= 1'b1;
    end else if (commit_pc) begin
      valid_q <= 1'b0;
    end
  end

  // PC advances only when the datapath retires the current instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (commit_pc) begin
      pc_q <= next_pc;
    end
  end

  next_pc_calc u_next_pc_calc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .next_pc  (next_pc)
  );

  assign pc_plus4    = pc_q + 32'd4;
  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = get_opcode(instr_q);
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: driver pushes expected fetch addresses and instructions,
// a monitor pops and compares whenever a request or a new valid instruction appears.
// The reference next-PC is computed with plain integer arithmetic from the ISA rules.
module tb_instr_fetch_unit;
  import cpu_isa_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_done;
  logic        branch;
  logic        zero;
  logic        jump;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RPC), .ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .exec_done   (exec_done),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump)
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_instr_t;

  logic [31:0] exp_addr_q[$];
  exp_instr_t  exp_instr_q[$];
  logic [31:0] model_pc;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: next PC from the architectural rules, written as plain arithmetic
  function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                           input logic b, input logic z, input logic j);
    logic [31:0] seq;
    logic [31:0] off;
    seq = cur_pc + 32'd4;
    if (j) return (seq & 32'hF000_0000) + (32'(word & 32'h03FF_FFFF) * 32'd4);
    if (b && z) begin
      off = 32'(word & 32'h0000_FFFF);
      if (off >= 32'h8000) off = off - 32'h1_0000;
      return seq + off * 32'd4;
    end
    return seq;
  endfunction

  function automatic logic [31:0] beq_word(input logic [15:0] imm);
    return {OP_BEQ, 10'd0, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [25:0] tgt);
    return {OP_J, tgt};
  endfunction

  // Monitor: compares request addresses and newly valid instructions against the queues
  initial begin : monitor
    logic       prev_req;
    logic       prev_valid;
    logic [31:0] held_addr;
    logic [31:0] held_instr;
    exp_instr_t e;
    prev_req   = 1'b0;
    prev_valid = 1'b0;
    held_addr  = '0;
    held_instr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_req   = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (imem_req && !prev_req) begin
          if (exp_addr_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_req: addr %h with no fetch expected", imem_addr);
          end else begin
            check("fetch_addr", imem_addr, exp_addr_q.pop_front());
          end
          held_addr = imem_addr;
        end else if (imem_req) begin
          check("addr_stable", imem_addr, held_addr);
        end
        if (imem_req) check("valid_low_in_fetch", instr_valid, 32'd0);
        if (instr_valid && !prev_valid) begin
          if (exp_instr_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_valid: instr %h with no fetch outstanding", instr);
          end else begin
            e = exp_instr_q.pop_front();
            check("instr", instr, e.word);
            check("opcode", opcode, 32'(e.word >> 26));
            check("pc", pc, e.addr);
            check("pc_plus4", pc_plus4, e.addr + 32'd4);
          end
          held_instr = instr;
        end else if (instr_valid) begin
          check("instr_held", instr, held_instr);
        end
        prev_req   = imem_req;
        prev_valid = instr_valid;
      end
    end
  end

  // Waits (from a negedge) for imem_req with a bounded budget
  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_timeout", imem_req, 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] word, input int delay);
    wait_req();
    for (int i = 0; i < delay; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      exec_done  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    exec_done  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_instr_q.push_back('{word, model_pc});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("valid_after_ack", instr_valid, 32'd1);
    check("req_low_in_exec", imem_req, 32'd0);
  endtask

  task automatic do_exec(input logic [31:0] word, input logic b, input logic z, input logic j,
                         input int delay);
    int n = 0;
    logic [31:0] nxt;
    while (!instr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", instr_valid, 32'd1);
    for (int i = 0; i < delay; i++) begin
      exec_done  = 1'b0;
      branch     = 1'($urandom_range(0, 1));
      zero       = 1'($urandom_range(0, 1));
      jump       = 1'($urandom_range(0, 1));
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
    end
    imem_ack  = 1'b0;
    branch    = b;
    zero      = z;
    jump      = j;
    exec_done = 1'b1;
    nxt = ref_next(model_pc, word, b, z, j);
    exp_addr_q.push_back(nxt);
    model_pc = nxt;
    @(negedge clk);
    exec_done = 1'b0;
    branch    = 1'($urandom_range(0, 1));
    zero      = 1'($urandom_range(0, 1));
    jump      = 1'($urandom_range(0, 1));
  endtask

  task automatic run_instr(input logic [31:0] word, input int fdelay, input logic b,
                           input logic z, input logic j, input int edelay);
    do_fetch(word, fdelay);
    do_exec(word, b, z, j, edelay);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks so far %0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    reset      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    exec_done  = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    jump       = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", imem_req, 32'd0);
    check("rst_valid", instr_valid, 32'd0);
    check("rst_pc", pc, RPC);
    check("rst_instr", instr, 32'd0);

    model_pc = RPC;
    exp_addr_q.push_back(RPC);
    reset = 1'b0;
    @(negedge clk);
    check("req_1cyc_after_reset", imem_req, 32'd1);

    // Directed walk through sequential, branch, jump and wrap cases
    run_instr(32'h2008_0005, 0, 1'b0, 1'b0, 1'b0, 0);      // 0 -> 4
    run_instr($urandom, 1, 1'b0, 1'b0, 1'b0, 1);           // 4 -> 8
    run_instr($urandom, 0, 1'b0, 1'b0, 1'b0, 0);           // 8 -> C
    run_instr($urandom, 0, 1'b0, 1'b0, 1'b0, 0);           // C -> 10
    run_instr(beq_word(16'hFFFE), 0, 1'b1, 1'b1, 1'b0, 0); // 10 -> C
    run_instr($urandom, 2, 1'b0, 1'b0, 1'b0, 0);           // C -> 10
    run_instr(beq_word(16'hFFFE), 0, 1'b1, 1'b0, 1'b0, 0); // 10 -> 14
    run_instr(j_word(26'h0), 5, 1'b0, 1'b0, 1'b1, 3);      // 14 -> 0, wait states + stray acks
    run_instr(beq_word(16'hFFFE), 0, 1'b1, 1'b1, 1'b0, 0); // 0 -> FFFF_FFFC
    run_instr($urandom, 0, 1'b0, 1'b0, 1'b0, 0);           // FFFF_FFFC -> 0
    run_instr(j_word(26'h2), 0, 1'b0, 1'b0, 1'b1, 0);      // 0 -> 8
    for (int i = 0; i < 2048; i++) begin                   // 8 -> 1000_0008 in max forward steps
      run_instr(beq_word(16'h7FFF), 0, 1'b1, 1'b1, 1'b0, 0);
    end
    run_instr(j_word(26'h40), 0, 1'b0, 1'b0, 1'b1, 0);     // -> 1000_0100
    run_instr(j_word(26'h2), 0, 1'b0, 1'b0, 1'b1, 0);      // -> 1000_0008
    run_instr(j_word(26'h40), 0, 1'b1, 1'b1, 1'b1, 1);     // jump beats branch -> 1000_0100

    // Reset while a request is outstanding
    wait_req();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("req_drops_async", imem_req, 32'd0);
    check("pc_after_fetch_reset", pc, RPC);
    model_pc = RPC;
    exp_addr_q.push_back(RPC);
    @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    reset    = 1'b0;
    run_instr($urandom, 1, 1'b0, 1'b0, 1'b0, 0);           // 0 -> 4

    // Reset while an instruction is executing
    do_fetch($urandom, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("valid_after_exec_reset", instr_valid, 32'd0);
    check("instr_after_exec_reset", instr, 32'd0);
    check("pc_after_exec_reset", pc, RPC);
    model_pc = RPC;
    exp_addr_q.push_back(RPC);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      run_instr($urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    check("addr_queue_drained", exp_addr_q.size(), 32'd0);
    check("instr_queue_drained", exp_instr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
